// File: rtl/asymfifo_push_arb_if.sv
// Push-side bundle between the requesters, the round-robin push arbiter and the
// narrow push port of an asymmetric FIFO.
interface asymfifo_push_arb_if #(
  parameter int num_req       = 4,
  parameter int data_in_width = 8
);
  localparam int OW = (num_req > 1) ? $clog2(num_req) : 1;

  logic [num_req-1:0]               req_n;
  logic [num_req*data_in_width-1:0] req_data;
  logic [num_req-1:0]               gnt_n;
  logic                             fifo_full;
  logic                             fifo_push_req_n;
  logic [data_in_width-1:0]         fifo_data_in;
  logic [OW-1:0]                    owner;
  logic                             busy;
  logic                             part_wd;

  modport master (
    input  req_n, req_data, fifo_full,
    output gnt_n, fifo_push_req_n, fifo_data_in, owner, busy, part_wd
  );

  modport slave (
    output req_n, req_data, fifo_full,
    input  gnt_n, fifo_push_req_n, fifo_data_in, owner, busy, part_wd
  );
endinterface

// File: rtl/asymfifo_push_arb.sv
// Round-robin arbiter for the narrow push port of an asymmetric FIFO; a grant is
// locked for a whole output word so packed words never mix sources.
module asymfifo_push_arb #(
  parameter int num_req        = 4,
  parameter int data_in_width  = 8,
  parameter int data_out_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  asymfifo_push_arb_if.master   bus
);
  localparam int RATIO = data_out_width / data_in_width;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OW    = (num_req > 1) ? $clog2(num_req) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                   state_q, state_d;
  logic [OW-1:0]            owner_q, owner_d;
  logic [OW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]            sel;
  logic                     found;
  int                       idx;
  logic                     push;
  logic [data_in_width-1:0] slice [num_req];

  assign push = (state_q == LOCK) && !bus.req_n[owner_q] && !bus.fifo_full;

  for (genvar gi = 0; gi < num_req; gi++) begin : g_req
    assign slice[gi]     = bus.req_data[gi*data_in_width +: data_in_width];
    assign bus.gnt_n[gi] = ~(push && (owner_q == OW'(gi)));
  end

  // Descending scan so the lowest offset from rr_ptr is the last to win.
  always_comb begin
    sel   = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = num_req - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % num_req;
      if (!bus.req_n[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = sel;
          state_d = LOCK;
        end
      end
      LOCK: begin
        // A stalled or withdrawn owner keeps the lock: the word must finish from it.
        if (push) begin
          if (beat_cnt_q == BW'(RATIO - 1)) begin
            beat_cnt_d = '0;
            rr_ptr_d   = (owner_q == OW'(num_req - 1)) ? '0 : owner_q + 1'b1;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_push_req_n = ~push;
  assign bus.fifo_data_in    = (state_q == LOCK) ? slice[owner_q] : '0;
  assign bus.owner           = owner_q;
  assign bus.busy            = (state_q == LOCK);
  assign bus.part_wd         = (beat_cnt_q != '0);
endmodule

// File: tb/tb_asymfifo_push_arb.sv
// Directed bench for asymfifo_push_arb: an 8->16 instance and an 8->32 instance,
// with a scoreboard of expected (owner, data) pushes.
module tb_asymfifo_push_arb;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q   [$];
  exp_t exp32_q [$];

  asymfifo_push_arb_if #(.num_req(4), .data_in_width(8)) a ();
  asymfifo_push_arb_if #(.num_req(4), .data_in_width(8)) b ();

  asymfifo_push_arb #(.num_req(4), .data_in_width(8), .data_out_width(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  asymfifo_push_arb #(.num_req(4), .data_in_width(8), .data_out_width(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp16(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.own = o;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic exp32(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.own = o;
    e.dat = d;
    exp32_q.push_back(e);
  endtask

  task automatic set16(input int i, input logic [7:0] d);
    a.req_data[i*8 +: 8] = d;
  endtask

  task automatic set32(input int i, input logic [7:0] d);
    b.req_data[i*8 +: 8] = d;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(a.busy), 32'd0);
    chk({tag, "_part"}, 32'(a.part_wd), 32'd0);
    chk({tag, "_push_n"}, 32'(a.fifo_push_req_n), 32'd1);
    chk({tag, "_gnt"}, 32'(a.gnt_n), 32'hf);
    chk({tag, "_data"}, 32'(a.fifo_data_in), 32'd0);
    chk({tag, "_owner"}, 32'(a.owner), 32'd0);
  endtask

  // Sample the current cycle's push, score it, then advance one clock.
  task automatic cyc();
    exp_t e;
    #1;
    if (a.fifo_push_req_n == 1'b0) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL push16_unexpected observed=%0h expected=none", a.fifo_data_in);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("push16_owner", 32'(a.owner), 32'(e.own));
        chk("push16_data", 32'(a.fifo_data_in), 32'(e.dat));
      end
    end
    if (b.fifo_push_req_n == 1'b0) begin
      checks++;
      assert (exp32_q.size() != 0) else begin
        failures++;
        $error("FAIL push32_unexpected observed=%0h expected=none", b.fifo_data_in);
      end
      if (exp32_q.size() != 0) begin
        e = exp32_q.pop_front();
        chk("push32_owner", 32'(b.owner), 32'(e.own));
        chk("push32_data", 32'(b.fifo_data_in), 32'(e.dat));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a.req_n     = 4'b0000;
    a.req_data  = '0;
    a.fifo_full = 1'b0;
    b.req_n     = 4'b1111;
    b.req_data  = '0;
    b.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) set16(i, 8'(8'h10 + i));

    // 1: reset with everything requesting, then rotation 0 -> 1
    repeat (2) @(posedge clk);
    #1;
    chk_reset("t1_rst");
    rst_n = 1'b1;
    exp16(2'd0, 8'h10);
    exp16(2'd0, 8'h10);
    cyc();
    chk("t1_c1_owner", 32'(a.owner), 32'd0);
    chk("t1_c1_busy", 32'(a.busy), 32'd1);
    chk("t1_c2_gnt", 32'(a.gnt_n), 32'he);
    chk("t1_c2_push_n", 32'(a.fifo_push_req_n), 32'd0);
    cyc();
    chk("t1_c3_gnt", 32'(a.gnt_n), 32'he);
    chk("t1_c3_part", 32'(a.part_wd), 32'd1);
    cyc();
    chk("t1_c4_busy", 32'(a.busy), 32'd0);
    chk("t1_c4_gnt", 32'(a.gnt_n), 32'hf);
    exp16(2'd1, 8'h11);
    exp16(2'd1, 8'h11);
    cyc();
    chk("t1_c5_owner", 32'(a.owner), 32'd1);
    cyc();
    cyc();
    a.req_n = 4'b1111;
    cyc();
    chk("t1_idle_busy", 32'(a.busy), 32'd0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: requester 2 alone, two distinct beats
    a.req_n = 4'b1011;
    set16(2, 8'hA1);
    cyc();
    chk("t2_owner", 32'(a.owner), 32'd2);
    exp16(2'd2, 8'hA1);
    exp16(2'd2, 8'hB2);
    cyc();
    chk("t2_part_mid", 32'(a.part_wd), 32'd1);
    set16(2, 8'hB2);
    cyc();
    a.req_n = 4'b1111;
    chk("t2_part_end", 32'(a.part_wd), 32'd0);
    chk("t2_busy_end", 32'(a.busy), 32'd0);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: all request, rr_ptr=3 picks 3; owner 3 withdraws mid-word
    for (int i = 0; i < 4; i++) set16(i, 8'(8'h40 + i));
    a.req_n = 4'b0000;
    cyc();
    chk("t4_owner3", 32'(a.owner), 32'd3);
    exp16(2'd3, 8'h43);
    cyc();
    a.req_n = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_hold_busy", 32'(a.busy), 32'd1);
      chk("t4_hold_part", 32'(a.part_wd), 32'd1);
      chk("t4_hold_push_n", 32'(a.fifo_push_req_n), 32'd1);
      chk("t4_hold_gnt", 32'(a.gnt_n), 32'hf);
      chk("t4_hold_owner", 32'(a.owner), 32'd3);
      cyc();
    end
    a.req_n = 4'b0000;
    exp16(2'd3, 8'h43);
    #1;
    chk("t4_resume_gnt", 32'(a.gnt_n), 32'h7);
    cyc();
    cyc();
    chk("t4_next_owner", 32'(a.owner), 32'd0);

    // 5: asynchronous reset with beat_cnt=1
    exp16(2'd0, 8'h40);
    cyc();
    chk("t5_part_pre", 32'(a.part_wd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("t5_rst");
    cyc();
    rst_n = 1'b1;
    a.req_n = 4'b1110;
    cyc();
    chk("t5_restart_owner", 32'(a.owner), 32'd0);
    chk("t5_restart_busy", 32'(a.busy), 32'd1);
    exp16(2'd0, 8'h40);
    exp16(2'd0, 8'h40);
    cyc();
    cyc();
    a.req_n = 4'b1111;
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: FIFO full for 5 cycles after the first beat of requester 1
    a.req_n = 4'b1101;
    set16(1, 8'h51);
    cyc();
    chk("t3_owner", 32'(a.owner), 32'd1);
    exp16(2'd1, 8'h51);
    cyc();
    a.fifo_full = 1'b1;
    a.req_n     = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_full_push_n", 32'(a.fifo_push_req_n), 32'd1);
      chk("t3_full_gnt", 32'(a.gnt_n), 32'hf);
      chk("t3_full_owner", 32'(a.owner), 32'd1);
      chk("t3_full_part", 32'(a.part_wd), 32'd1);
      cyc();
    end
    a.fifo_full = 1'b0;
    a.req_n     = 4'b1101;
    set16(1, 8'h52);
    exp16(2'd1, 8'h52);
    #1;
    chk("t3_release_push_n", 32'(a.fifo_push_req_n), 32'd0);
    chk("t3_release_gnt", 32'(a.gnt_n), 32'hd);
    cyc();
    a.req_n = 4'b1111;
    cyc();
    chk("t3_busy_end", 32'(a.busy), 32'd0);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: 8->32 instance, four beats per word, owners 0,1,2,3,0
    for (int i = 0; i < 4; i++) set32(i, 8'(8'h60 + i));
    b.req_n = 4'b0000;
    for (int w = 0; w < 5; w++) begin
      #1;
      chk("t6_idle_busy", 32'(b.busy), 32'd0);
      chk("t6_idle_push_n", 32'(b.fifo_push_req_n), 32'd1);
      cyc();
      for (int k = 0; k < 4; k++) begin
        exp32(2'(w % 4), 8'(8'h60 + (w % 4)));
        #1;
        chk("t6_owner", 32'(b.owner), 32'(w % 4));
        chk("t6_push_n", 32'(b.fifo_push_req_n), 32'd0);
        cyc();
      end
    end
    b.req_n = 4'b1111;
    cyc();
    chk("t6_busy_end", 32'(b.busy), 32'd0);
    chk("t6_sb_empty", 32'(exp32_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
